// File: rtl/mmio_periph_array.sv
// mmio_periph_array: memory-mapped PWM bank with double-buffered duties,
// free-running micro/millisecond timers and a millisecond compare interrupt.
module mmio_periph_array #(
  parameter int NUM_PWM = 4,
  parameter int PWM_BITS = 8,
  parameter int CLK_HZ = 12000000,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_mem,
  input  logic [2:0]         funct3,
  input  logic [31:0]        write_address,
  input  logic [31:0]        write_data,
  input  logic [31:0]        read_address,
  output logic [31:0]        read_data,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               irq
);
  localparam int US_DIV = CLK_HZ / 1000000;
  localparam int MS_DIV = CLK_HZ / 1000;
  logic [PWM_BITS-1:0] shadow [NUM_PWM];
  logic [PWM_BITS-1:0] active [NUM_PWM];
  logic [PWM_BITS-1:0] cnt;
  logic [31:0] millis, micros, cmp, us_pre, ms_pre, rd_word, rd_val, duty_rd;
  logic [1:0] ctrl, rd_lane;
  logic [2:0] rd_f3;
  logic [15:0] half;
  logic [7:0] byte_v;
  logic [5:0] widx, ridx;
  logic pend, ms_tick, wen, rin, clr;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] a, input logic [2:0] f);
    logic [31:0] m, v;
    m = f[1] ? 32'hFFFFFFFF : f[0] ? 32'h0000FFFF << {a[1], 4'b0} : 32'h000000FF << {a, 3'b0};
    v = f[1] ? d : f[0] ? d << {a[1], 4'b0} : d << {a, 3'b0};
    return (old & ~m) | (v & m);
  endfunction
  assign wen = write_mem && write_address[31:8] == BASE_ADDR[31:8];
  assign rin = read_address[31:8] == BASE_ADDR[31:8];
  assign widx = write_address[7:2];
  assign ridx = read_address[7:2];
  assign clr = wen && widx == 6'd19 &&
               (merge(32'h0, write_data, write_address[1:0], funct3) & 32'h1) != 32'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      us_pre <= '0;
      ms_pre <= '0;
      micros <= '0;
      millis <= '0;
      ms_tick <= 1'b0;
      cmp <= '0;
      pend <= 1'b0;
      ctrl <= '0;
      rd_word <= '0;
      rd_lane <= '0;
      rd_f3 <= '0;
      for (int k = 0; k < NUM_PWM; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      cnt <= cnt + 1'b1;
      us_pre <= us_pre == 32'(US_DIV - 1) ? '0 : us_pre + 32'd1;
      micros <= micros + 32'(us_pre == 32'(US_DIV - 1));
      ms_pre <= ms_pre == 32'(MS_DIV - 1) ? '0 : ms_pre + 32'd1;
      millis <= millis + 32'(ms_pre == 32'(MS_DIV - 1));
      // compare is evaluated the cycle after MILLIS has moved, so CMP writes alone never hit
      ms_tick <= ms_pre == 32'(MS_DIV - 1);
      pend <= (ms_tick && millis == cmp) || (pend && !clr);
      rd_word <= rd_val;
      rd_lane <= read_address[1:0];
      rd_f3 <= funct3;
      if (wen && widx == 6'd18) cmp <= merge(cmp, write_data, write_address[1:0], funct3);
      if (wen && widx == 6'd20) ctrl <= 2'(merge({30'b0, ctrl}, write_data, write_address[1:0], funct3));
      for (int k = 0; k < NUM_PWM; k++) begin
        if (&cnt) active[k] <= shadow[k];
        if (wen && widx == 6'(k))
          shadow[k] <= PWM_BITS'(merge(32'(shadow[k]), write_data, write_address[1:0], funct3));
      end
    end
  end
  always_comb begin
    duty_rd = '0;
    for (int k = 0; k < NUM_PWM; k++) if (ridx == 6'(k)) duty_rd = 32'(shadow[k]);
    rd_val = !rin ? '0 : ridx == 6'd16 ? millis : ridx == 6'd17 ? micros : ridx == 6'd18 ? cmp :
             ridx == 6'd19 ? {31'b0, pend} : ridx == 6'd20 ? {30'b0, ctrl} : duty_rd;
  end
  assign half = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign byte_v = rd_word[{rd_lane, 3'b0} +: 8];
  assign read_data = rd_f3[1] ? rd_word :
                     rd_f3[0] ? {{16{~rd_f3[2] & half[15]}}, half} : {{24{~rd_f3[2] & byte_v[7]}}, byte_v};
  always_comb begin
    pwm_out = '0;
    for (int k = 0; k < NUM_PWM; k++) pwm_out[k] = ctrl[1] && cnt < active[k];
  end
  assign irq = pend & ctrl[0];
endmodule

// File: tb/tb_mmio_periph_array.sv
// tb_mmio_periph_array: directed vectors against a cycle-count based model of the peripheral array.
module tb_mmio_periph_array;
  localparam logic [31:0] B = 32'hFFFFFF00;
  logic clk = 0, rst = 1, write_mem = 0;
  logic [2:0] funct3 = 3'b010;
  logic [31:0] write_address = 0, write_data = 0, read_address = 0;
  logic [31:0] read_data;
  logic [3:0] pwm_out;
  logic irq;
  int applied = 0, miscompares = 0;
  mmio_periph_array dut (.clk(clk), .rst(rst), .write_mem(write_mem), .funct3(funct3),
    .write_address(write_address), .write_data(write_data), .read_address(read_address),
    .read_data(read_data), .pwm_out(pwm_out), .irq(irq));
  always #5 clk = ~clk;
  // model: everything time-based is derived from n, the number of clock edges since reset
  int unsigned n;
  logic [31:0] m_cmp, m_rd, off, nv;
  logic m_pend, set_p, clr;
  logic [1:0] m_ctrl;
  logic [7:0] m_sh [4], m_act [4];
  logic [3:0] ep;
  function automatic logic [31:0] model_reg(input logic [31:0] a);
    logic [31:0] o;
    if (a < B) return 0;
    o = (a - B) & ~32'd3;
    if (o < 16) return {24'b0, m_sh[o / 4]};
    if (o == 'h40) return n / 12000;
    if (o == 'h44) return n / 12;
    if (o == 'h48) return m_cmp;
    if (o == 'h4C) return {31'b0, m_pend};
    if (o == 'h50) return {30'b0, m_ctrl};
    return 0;
  endfunction
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f);
    logic [31:0] v;
    if (f[1]) return w;
    if (f[0]) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (!f[2] && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = (w >> (8 * a)) & 32'hFF;
      if (!f[2] && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction
  function automatic logic [31:0] put(input logic [31:0] old, input logic [31:0] d,
                                      input logic [1:0] a, input logic [2:0] f);
    int sz = f[1] ? 4 : f[0] ? 2 : 1;
    int lane = f[1] ? 0 : f[0] ? 2 * a[1] : int'(a);
    logic [31:0] r = old;
    for (int i = 0; i < sz; i++) r[8 * (lane + i) +: 8] = d[8 * i +: 8];
    return r;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_cmp = 0; m_pend = 0; m_ctrl = 0; m_rd = 0;
      for (int k = 0; k < 4; k++) begin m_sh[k] = 0; m_act[k] = 0; end
    end else begin
      m_rd = ext(model_reg(read_address), read_address[1:0], funct3);
      set_p = n != 0 && n % 12000 == 0 && n / 12000 == m_cmp;
      clr = 0;
      if (n % 256 == 255) for (int k = 0; k < 4; k++) m_act[k] = m_sh[k];
      if (write_mem && write_address >= B) begin
        off = (write_address - B) & ~32'd3;
        if (off < 16) begin
          nv = put({24'b0, m_sh[off / 4]}, write_data, write_address[1:0], funct3);
          m_sh[off / 4] = nv[7:0];
        end
        if (off == 'h48) m_cmp = put(m_cmp, write_data, write_address[1:0], funct3);
        if (off == 'h4C) begin
          nv = put(0, write_data, write_address[1:0], funct3);
          clr = nv[0];
        end
        if (off == 'h50) begin
          nv = put({30'b0, m_ctrl}, write_data, write_address[1:0], funct3);
          m_ctrl = nv[1:0];
        end
      end
      m_pend = set_p | (m_pend & !clr);
      n++;
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) ep[k] = m_ctrl[1] && (n % 256) < m_act[k];
    applied += 3;
    if (pwm_out !== ep) begin
      miscompares++;
      $display("FAIL pwm_out n=%0d got %h want %h", n, pwm_out, ep);
    end
    if (irq !== (m_pend & m_ctrl[0])) begin
      miscompares++;
      $display("FAIL irq n=%0d got %b want %b", n, irq, m_pend & m_ctrl[0]);
    end
    if (read_data !== m_rd) begin
      miscompares++;
      $display("FAIL read_data n=%0d got %h want %h", n, read_data, m_rd);
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    write_mem = 1; write_address = a; write_data = d; funct3 = f;
    @(posedge clk); #2;
    write_mem = 0;
  endtask
  task automatic rd(input string name, input logic [31:0] a, input logic [2:0] f, input logic [31:0] want);
    read_address = a; funct3 = f;
    @(posedge clk); #2;
    chk(name, read_data, want);
  endtask
  task automatic wait_n(input int unsigned target);
    int guard = 0;
    while (n < target) begin
      @(posedge clk); #2;
      if (++guard > 90000) begin
        $display("FAIL wait_n timeout target %0d n %0d", target, n);
        $fatal(1, "wait bound expired");
      end
    end
  endtask
  task automatic count_pwm(output int c [4]);
    for (int k = 0; k < 4; k++) c[k] = 0;
    repeat (256) begin
      @(posedge clk); #2;
      for (int k = 0; k < 4; k++) c[k] += int'(pwm_out[k]);
    end
  endtask
  int c [4];
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_pwm", {28'b0, pwm_out}, 0);
    chk("reset_irq", {31'b0, irq}, 0);
    chk("reset_rd", read_data, 0);
    rst = 0;
    rd("ctrl_reset", B + 'h50, 3'b010, 0);
    wr(B + 'h50, 2, 3'b010);
    wr(B + 'h00, 32'h40, 3'b010);
    wr(B + 'h04, 32'h00FF, 3'b001);
    repeat (512) @(posedge clk);
    #2;
    count_pwm(c);
    chk("pwm0_high", c[0], 64);
    chk("pwm1_fullscale", c[1], 255);
    chk("pwm2_zero", c[2], 0);
    rd("duty0_rd", B + 'h00, 3'b010, 32'h40);
    wr(B + 'h49, 32'h80, 3'b000);
    rd("cmp_word", B + 'h48, 3'b010, 32'h00008000);
    rd("cmp_lb", B + 'h49, 3'b000, 32'hFFFFFF80);
    rd("cmp_lbu", B + 'h49, 3'b100, 32'h00000080);
    rd("cmp_lh", B + 'h48, 3'b001, 32'hFFFF8000);
    rd("cmp_lhu_hi", B + 'h4A, 3'b101, 0);
    wr(B - 4, 32'hDEADBEEF, 3'b010);
    wr(B + 'h60, 32'h1, 3'b010);
    rd("below_window", B - 4, 3'b010, 0);
    rd("unmapped", B + 'h60, 3'b010, 0);
    rd("cmp_kept", B + 'h48, 3'b010, 32'h8000);
    rd("ctrl_kept", B + 'h50, 3'b010, 2);
    read_address = B + 'h48;
    wr(B + 'h48, 3, 3'b010);
    chk("rd_during_wr", read_data, 32'h8000);
    rd("cmp_new", B + 'h48, 3'b010, 3);
    wr(B + 'h50, 1, 3'b010);
    wait_n(12000);
    rd("millis_12000", B + 'h40, 3'b010, 1);
    rd("micros_12000", B + 'h44, 3'b010, 1000);
    wait_n(36000);
    chk("irq_before", {31'b0, irq}, 0);
    @(posedge clk); #2;
    chk("irq_rise", {31'b0, irq}, 1);
    wr(B + 'h4C, 1, 3'b010);
    chk("irq_w1c", {31'b0, irq}, 0);
    wr(B + 'h48, 3, 3'b010);
    repeat (3) @(posedge clk);
    #2;
    chk("cmp_write_no_pend", {31'b0, irq}, 0);
    wr(B + 'h48, 4, 3'b010);
    wait_n(48000);
    wr(B + 'h4C, 1, 3'b010);
    chk("set_beats_clear", {31'b0, irq}, 1);
    wr(B + 'h50, 3, 3'b010);
    wait_n(60000);
    rd("millis_5", B + 'h40, 3'b010, 5);
    chk("pend_before_rst", {31'b0, irq}, 1);
    read_address = B + 'h04;
    rst = 1;
    #1;
    chk("rst_pwm", {28'b0, pwm_out}, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_rd", read_data, 0);
    @(posedge clk); #2;
    rst = 0;
    rd("rst_duty1", B + 'h04, 3'b010, 0);
    rd("rst_cmp", B + 'h48, 3'b010, 0);
    rd("rst_status", B + 'h4C, 3'b010, 0);
    rd("rst_ctrl", B + 'h50, 3'b010, 0);
    rd("rst_millis", B + 'h40, 3'b010, 0);
    repeat (4) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/mmio_periph_array.md
MMIO_PERIPH_ARRAY -- requirements
Module: mmio_periph_array

Interface
REQ-001 SHALL have parameter NUM_PWM, default 4, number of PWM channels, legal range 1..8.
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter and duty width, legal range 4..16.
REQ-003 SHALL have parameter CLK_HZ, default 12000000, clock frequency; it SHALL be an integer multiple of 1000000.
REQ-004 SHALL have parameter BASE_ADDR, default 32'hFFFFFF00, 256-byte-aligned base of the register window.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 write_mem  input  1  write strobe, sampled at the rising edge.
REQ-008 funct3  input  3  access size and sign; same encoding as RV32I loads and stores.
REQ-009 write_address  input  32  byte address of the write.
REQ-010 write_data  input  32  write data, right-aligned.
REQ-011 read_address  input  32  byte address of the read.
REQ-012 read_data  output  32  read result, valid one cycle after read_address is presented.
REQ-013 pwm_out  output  NUM_PWM  active-high PWM outputs, one bit per channel.
REQ-014 irq  output  1  level interrupt, high while the compare flag and the interrupt enable are both set.

Function
REQ-015 Register map as word offsets from BASE_ADDR:
- 0x00+4k: DUTY[k], R/W, for k<NUM_PWM; bits [PWM_BITS-1:0] used, upper bits read 0.
- 0x40: MILLIS, R.
- 0x44: MICROS, R.
- 0x48: CMP, R/W, 32 bits.
- 0x4C: STATUS, bit0 PEND, write-1-to-clear.
- 0x50: CTRL, R/W; bit0 IRQ_EN, bit1 PWM_EN.
- All other offsets read 0; writes to them are ignored.
REQ-016 Writes to addresses outside [BASE_ADDR, BASE_ADDR+0xFF] SHALL be ignored; reads of those addresses SHALL return 0.
REQ-017 Write size SHALL follow funct3[1:0]:
- 10: full word.
- 01: halfword; write_address[1] selects the lane.
- 00: byte; write_address[1:0] selects the lane.
- Unselected bits of the register SHALL be kept.
REQ-018 Read path:
- Register value SHALL be captured on the clock edge.
- Lane select and sign/zero extension SHALL be applied combinationally, using the captured address[1:0] and captured funct3.
- funct3[2]=1 SHALL zero-extend; funct3[2]=0 SHALL sign-extend.
REQ-019 Each PWM_BITS-bit counter SHALL increment every cycle and wrap from 2^PWM_BITS-1 to 0.
REQ-020 Each duty channel SHALL have an active register and a shadow register:
- A write updates the shadow register only.
- The shadow copies into the active register in the cycle the counter wraps to 0.
- DUTY reads return the shadow value.
REQ-021 pwm_out[k] SHALL equal PWM_EN & (counter < active[k]); duty 0 gives always low, a full-scale duty gives low for exactly 1 cycle per period.
REQ-022 MICROS SHALL increment by 1 every CLK_HZ/1000000 cycles; it SHALL use a prescaler counting 0..CLK_HZ/1000000-1 and wrap mod 2^32.
REQ-023 MILLIS SHALL increment by 1 every CLK_HZ/1000 cycles, using its own prescaler, and wrap mod 2^32.
REQ-024 PEND SHALL set in the cycle after MILLIS increments to a value equal to CMP.
REQ-025 A W1C write to STATUS in the same cycle as a PEND set event: set SHALL win.
REQ-026 Writing CMP SHALL NOT set PEND, even if CMP equals the current MILLIS.
REQ-027 irq SHALL equal PEND & IRQ_EN, registered-free: it is a combinational AND of the two flops.
REQ-028 A simultaneous read and write to the same register SHALL return the pre-write value.

Reset
REQ-029 While rst is high, the following SHALL be 0:
- all registers (DUTY shadow and active, CMP, STATUS, CTRL);
- MILLIS, MICROS and both prescalers;
- the PWM counter;
- the read capture register.
REQ-030 While rst is high, pwm_out, irq and read_data SHALL be 0.
REQ-031 Reset asserted mid-period or mid-prescale SHALL abort immediately, with no partial update.
REQ-032 After rst deasserts, counting SHALL start on the first rising edge.

Verification
REQ-033 Defaults, CTRL=2, DUTY[0]=0x40 by word write: after the next counter wrap, pwm_out[0] SHALL be high for 64 of 256 cycles per period.
REQ-034 CLK_HZ=12000000: after 12000 cycles from reset, MILLIS SHALL read 1 and MICROS SHALL read 1000.
REQ-035 CMP=3, CTRL=1: irq SHALL rise 1 cycle after MILLIS becomes 3; writing STATUS=1 SHALL drop irq on the next cycle.
REQ-036 Byte write of 0x80 to BASE_ADDR+0x49 with CMP initially 0: CMP SHALL read 0x00008000; an lb from BASE_ADDR+0x49 SHALL return 0xFFFFFF80, and an lbu SHALL return 0x00000080.
REQ-037 Assert rst for 1 cycle while PEND=1, DUTY[1]=0xFF and MILLIS=5: all outputs SHALL be 0 immediately, and all reads SHALL return 0.
REQ-038 Write to BASE_ADDR-4 and BASE_ADDR+0x60: no register SHALL change; a read of BASE_ADDR-4 SHALL return 0.
